// File: rtl/dna_hash_pkg.sv
// Shared definitions for the DNA k-mer hash engine: ASCII base constants,
// 2-bit base codes, the base encoder and the window mask helper.
package dna_hash_pkg;

  localparam logic [7:0] AsciiA = 8'h41;
  localparam logic [7:0] AsciiC = 8'h43;
  localparam logic [7:0] AsciiG = 8'h47;
  localparam logic [7:0] AsciiT = 8'h54;

  typedef enum logic [1:0] {
    BaseA = 2'd0,
    BaseC = 2'd1,
    BaseG = 2'd2,
    BaseT = 2'd3
  } base_code_t;

  typedef struct packed {
    logic       valid;
    base_code_t code;
  } base_enc_t;

  // Non-bases encode as {valid=0, code=A} so callers can use the code blindly.
  function automatic base_enc_t encode_base(input logic [7:0] ch);
    base_enc_t  r;
    logic [7:0] up;
    up = ch & ~8'h20;
    r  = '0;
    case (up)
      AsciiA:  r = '{valid: 1'b1, code: BaseA};
      AsciiC:  r = '{valid: 1'b1, code: BaseC};
      AsciiG:  r = '{valid: 1'b1, code: BaseG};
      AsciiT:  r = '{valid: 1'b1, code: BaseT};
      default: r = '0;
    endcase
    return r;
  endfunction

  // 2*k ones in the low bits; k is limited to 1..16 so 64 bits always suffice.
  function automatic logic [63:0] kmer_mask(input int unsigned k);
    return (64'd1 << (2 * k)) - 64'd1;
  endfunction

endpackage

// File: rtl/dna_kmer_hash_unit_if.sv
// Signal bundle for the k-mer hash unit: streaming byte path plus the
// combinational rolling-step path.
interface dna_kmer_hash_unit_if #(
  parameter int unsigned HASH_W = 32
);

  logic [7:0]        char_in;
  logic [HASH_W-1:0] hash_out;
  logic              done;
  logic              invalid;

  logic [HASH_W-1:0] prev_hash;
  logic [7:0]        out_char;
  logic [7:0]        in_char;
  logic [HASH_W-1:0] new_hash;
  logic              roll_err;

  modport master (
    output char_in, prev_hash, out_char, in_char,
    input  hash_out, done, invalid, new_hash, roll_err
  );

  modport slave (
    input  char_in, prev_hash, out_char, in_char,
    output hash_out, done, invalid, new_hash, roll_err
  );

endinterface

// File: rtl/dna_roll_step.sv
// Combinational rolling-hash step: drop the oldest base, append the newest.
module dna_roll_step #(
  parameter int unsigned K      = 4,
  parameter int unsigned HASH_W = 32
) (
  input  logic [HASH_W-1:0] prev_hash,
  input  logic [7:0]        out_char,
  input  logic [7:0]        in_char,
  output logic [HASH_W-1:0] new_hash,
  output logic              roll_err
);
  import dna_hash_pkg::*;

  localparam logic [HASH_W-1:0] Mask = HASH_W'(kmer_mask(K));

  base_enc_t         enc_out;
  base_enc_t         enc_in;
  logic [HASH_W-1:0] out_term;
  logic [HASH_W-1:0] dropped;

  always_comb begin
    enc_out  = encode_base(out_char);
    enc_in   = encode_base(in_char);
    out_term = HASH_W'(enc_out.code) << (2 * (K - 1));
    // Subtraction wraps modulo 2^HASH_W; masking afterwards trims the window.
    dropped  = prev_hash - out_term;
    new_hash = ((dropped << 2) | HASH_W'(enc_in.code)) & Mask;
    roll_err = ~enc_out.valid | ~enc_in.valid;
  end

endmodule

// File: rtl/dna_kmer_hash_unit.sv
// Streaming base-4 k-mer hash: accumulates ASCII bases into a K-base window,
// flags the first full window and pulses on non-base bytes.
module dna_kmer_hash_unit #(
  parameter int unsigned K      = 4,
  parameter int unsigned HASH_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  dna_kmer_hash_unit_if.slave bus
);
  import dna_hash_pkg::*;

  localparam int unsigned       CntW = $clog2(K + 1);
  localparam logic [CntW-1:0]   KCnt = CntW'(K);
  localparam logic [HASH_W-1:0] Mask = HASH_W'(kmer_mask(K));

  logic [HASH_W-1:0] hash_q, hash_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              invalid_q, invalid_d;
  base_enc_t         enc;

  always_comb begin
    enc       = encode_base(bus.char_in);
    hash_d    = hash_q;
    count_d   = count_q;
    invalid_d = 1'b0;
    // 0x00 is idle and leaves all state untouched.
    if (bus.char_in != 8'h00) begin
      if (enc.valid) begin
        hash_d = ((hash_q << 2) | HASH_W'(enc.code)) & Mask;
        if (count_q != KCnt) begin
          count_d = count_q + CntW'(1);
        end
      end else begin
        invalid_d = 1'b1;
      end
    end
    done_d = (count_d == KCnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hash_q    <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      hash_q    <= hash_d;
      count_q   <= count_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.hash_out = hash_q;
  assign bus.done     = done_q;
  assign bus.invalid  = invalid_q;

  dna_roll_step #(
    .K      (K),
    .HASH_W (HASH_W)
  ) u_roll_step (
    .prev_hash (bus.prev_hash),
    .out_char  (bus.out_char),
    .in_char   (bus.in_char),
    .new_hash  (bus.new_hash),
    .roll_err  (bus.roll_err)
  );

endmodule

// File: tb/tb_dna_kmer_hash_unit.sv
// Self-checking bench for dna_kmer_hash_unit: directed streaming and rolling
// steps, with streaming expectations queued from a small reference model.
module tb_dna_kmer_hash_unit;

  localparam int unsigned K    = 4;
  localparam int unsigned HW   = 32;
  localparam logic [31:0] MASK = 32'h0000_00FF;

  typedef struct {
    logic [31:0] hash;
    logic        done;
    logic        invalid;
  } exp_t;

  logic clk;
  logic rst;

  dna_kmer_hash_unit_if #(.HASH_W(HW)) bus ();

  dna_kmer_hash_unit #(
    .K      (K),
    .HASH_W (HW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  exp_t        sb[$];
  logic [7:0]  win[$];
  logic [31:0] m_hash;
  int unsigned m_cnt;

  function automatic logic [2:0] tb_code(input logic [7:0] ch);
    case (ch)
      8'h41, 8'h61: return 3'b100;
      8'h43, 8'h63: return 3'b101;
      8'h47, 8'h67: return 3'b110;
      8'h54, 8'h74: return 3'b111;
      default:      return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] roll_model(input logic [31:0] prev, input logic [7:0] oc,
                                             input logic [7:0] ic);
    logic [2:0] co;
    logic [2:0] ci;
    co = tb_code(oc);
    ci = tb_code(ic);
    return (((prev - (32'(co[1:0]) << (2 * (K - 1)))) << 2) | 32'(ci[1:0])) & MASK;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_hash = '0;
    m_cnt  = 0;
    win.delete();
    sb.delete();
  endtask

  // Drive one byte for one cycle; expectations go through the scoreboard.
  task automatic step(input logic [7:0] ch);
    exp_t       e;
    logic [2:0] c;
    @(negedge clk);
    bus.char_in = ch;
    c = tb_code(ch);
    e.invalid = 1'b0;
    if (ch != 8'h00) begin
      if (c[2]) begin
        m_hash = ((m_hash << 2) | 32'(c[1:0])) & MASK;
        if (m_cnt < K) m_cnt++;
        win.push_back(ch);
        if (win.size() > K) void'(win.pop_front());
      end else begin
        e.invalid = 1'b1;
      end
    end
    e.hash = m_hash;
    e.done = (m_cnt == K);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.char_in = 8'h00;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check("stream_hash", bus.hash_out, e.hash);
      check("stream_done", 32'(bus.done), 32'(e.done));
      check("stream_invalid", 32'(bus.invalid), 32'(e.invalid));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    check("rst_hash", bus.hash_out, 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_invalid", 32'(bus.invalid), 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic roll(input logic [31:0] prev, input logic [7:0] oc, input logic [7:0] ic,
                      input logic [31:0] exp_hash, input logic exp_err);
    bus.prev_hash = prev;
    bus.out_char  = oc;
    bus.in_char   = ic;
    #1;
    check("roll_new_hash", bus.new_hash, exp_hash);
    check("roll_err", 32'(bus.roll_err), 32'(exp_err));
  endtask

  initial begin
    logic [7:0]  bases[4];
    logic [7:0]  ch;
    logic [7:0]  oldest;
    logic [31:0] prev;

    bases[0] = "A"; bases[1] = "C"; bases[2] = "G"; bases[3] = "T";
    rst           = 1'b0;
    bus.char_in   = 8'h00;
    bus.prev_hash = '0;
    bus.out_char  = 8'h00;
    bus.in_char   = 8'h00;
    model_clear();
    #1;
    check("por_hash", bus.hash_out, 32'h0);
    check("por_done", 32'(bus.done), 32'h0);
    check("por_invalid", 32'(bus.invalid), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ATCG fills the window.
    step("A"); step("T"); step("C");
    check("atcg_not_done_yet", 32'(bus.done), 32'h0);
    step("G");
    check("atcg_hash", bus.hash_out, 32'h36);
    check("atcg_done", 32'(bus.done), 32'h1);

    // Rolling step agrees with streaming a 5th base.
    roll(32'h36, "A", "G", 32'hDA, 1'b0);
    step("G");
    check("fifth_base_hash", bus.hash_out, 32'hDA);

    // All-T window, its roll, and the lowercase equivalent.
    do_reset();
    step("T"); step("T"); step("T"); step("T");
    check("tttt_hash", bus.hash_out, 32'hFF);
    roll(32'hFF, "T", "A", 32'hFC, 1'b0);
    do_reset();
    step("t"); step("t"); step("t"); step("t");
    check("lower_tttt_hash", bus.hash_out, 32'hFF);

    // Non-base and idle bytes interleaved.
    do_reset();
    step("A"); step(8'h00); step("N"); step(8'h00); step("T"); step("C");
    check("mixed_not_done", 32'(bus.done), 32'h0);
    step("G");
    check("mixed_hash", bus.hash_out, 32'h36);
    check("mixed_done", 32'(bus.done), 32'h1);

    // Asynchronous reset with a full window held.
    step("C"); step("C");
    check("pre_rst_done", 32'(bus.done), 32'h1);
    do_reset();
    step("C"); step("C"); step("C"); step("C");
    check("cccc_hash", bus.hash_out, 32'h55);
    check("cccc_done", 32'(bus.done), 32'h1);

    // Non-base roll inputs count as code 0.
    roll(32'h55, "C", "X", 32'h54, 1'b1);
    roll(32'h36, "Z", "T", 32'hDB, 1'b1);
    roll(32'h36, "a", "g", 32'hDA, 1'b0);

    // Rolling step consistency over a pseudo-random stream.
    for (int i = 0; i < 24; i++) begin
      ch     = bases[$urandom_range(0, 3)];
      prev   = m_hash;
      oldest = win[0];
      roll(prev, oldest, ch, roll_model(prev, oldest, ch), 1'b0);
      step(ch);
      check("roll_vs_stream", bus.new_hash, bus.hash_out);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dna_kmer_hash_unit.md
Name: dna_kmer_hash_unit

Overview:
Streaming 2-bit-per-base hash engine for DNA k-mers. It accumulates ASCII nucleotides into a base-4 hash of the most recent K bases. It raises done once a full window is held. It also provides a combinational rolling-hash step (drop oldest base, append newest) for software-style window advancement. It sits between the sequence byte stream and the k-mer lookup/compare stage.

Parameters:
K, 4, k-mer window length in bases; legal range 1..16.
HASH_W, 32, width of all hash ports; must be >= 2*K.

Ports:
clk  in  1  system clock, rising-edge active.
rst  in  1  asynchronous, active-low reset.
char_in  in  8  ASCII nucleotide, sampled every rising edge; 0x00 = idle.
hash_out  out  HASH_W  base-4 hash of the last K accepted bases; bits above 2*K are always 0.
done  out  1  high once K valid bases have been accepted since reset.
invalid  out  1  registered one-cycle pulse: char_in was non-zero and not a base.
prev_hash  in  HASH_W  rolling step: current window hash.
out_char  in  8  rolling step: ASCII base leaving the window (oldest).
in_char  in  8  rolling step: ASCII base entering the window.
new_hash  out  HASH_W  rolling step result, combinational.
roll_err  out  1  combinational: out_char or in_char is not a base.

Behaviour:
- Base code, case-insensitive:
  - A/a = 0, C/c = 1, G/g = 2, T/t = 3.
  - Any other byte is a non-base.
- Reset (rst = 0, asynchronous): hash_out = 0, done = 0, invalid = 0, internal count = 0.
- Rising edge with char_in a valid base:
  - hash_out <= ((hash_out << 2) | code) & MASK, where MASK = 2^(2K) - 1.
  - count <= min(count + 1, K).
- Rising edge with char_in = 0x00: no state change.
- Rising edge with char_in non-zero and not a base:
  - No shift, count unchanged.
  - invalid = 1 for exactly that next cycle.
- done = (count == K), registered.
  - Rises on the same edge that captures the K-th valid base, so it is visible one cycle after that base is presented.
  - Stays high until reset.
- After done, every further valid base slides the window.
  - hash_out is always the hash of the last K accepted bases.
  - Most significant pair of bits = oldest base.
- Latency: one clock from char_in to hash_out, done and invalid.
- No backpressure; one base may be accepted per cycle.
- Rolling step, purely combinational, zero latency:
  - new_hash = (((prev_hash - (code(out_char) << 2*(K-1))) << 2) | code(in_char)) & MASK.
  - Subtraction is modulo 2^HASH_W before masking.
- Non-base on out_char or in_char:
  - That code is taken as 0.
  - roll_err = 1.
- The rolling path is independent of clk/rst and of the streaming state.
- Consistency requirement: for any full window W and next base b, new_hash(hash(W), oldest(W), b) equals the streaming hash_out after b is accepted.
- Reset mid-stream: window fill restarts from zero; done drops immediately (asynchronous).

Decomposition:
- Shared package dna_hash_pkg holds:
  - ASCII constants for A/C/G/T.
  - The 2-bit base code typedef.
  - A base-encode function returning {valid, code}.
  - The MASK helper.
- One natural sub-module, dna_roll_step: the combinational rolling datapath behind new_hash/roll_err.
- The top level holds the accumulator register, the count/done logic and the invalid pulse.

Test Plan:
- Reset, then "A","T","C","G" on consecutive edges -> done rises after 4th edge; hash_out = 0x36; invalid never pulses.
- Rolling step prev_hash = 0x36, out_char = 'A', in_char = 'G' -> new_hash = 0xDA, roll_err = 0. Streaming a 5th base 'G' then gives hash_out = 0xDA.
- "T","T","T","T" -> hash_out = 0xFF. Roll out 'T', in 'A' -> new_hash = 0xFC. Lowercase "tttt" gives the same hash.
- "A","N","T","C","G" -> 'N' ignored: invalid pulses one cycle, hash_out = 0x36, done after 'G'. Idle 0x00 between bases is also ignored.
- Assert rst after 2 bases -> hash_out = 0 and done = 0 immediately. Refill "CCCC" -> 0x55, done.
- Roll with in_char = 'X' -> roll_err = 1; the in_char code is treated as 0.
